// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-side hazard signals between the core and the hazard unit
interface hazard_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       if_id_rs1;
  logic [4:0]       if_id_rs2;
  logic             if_id_use_rs1;
  logic             if_id_use_rs2;
  logic [4:0]       id_ex_rd;
  logic             id_ex_mem_re;
  logic             id_ex_mc_start;
  logic             mc_done;
  logic             branch_taken;
  logic             stall_clr;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_hold;
  logic             mc_error;
  logic [CNT_W-1:0] stall_count;

  // Pipeline side: reports stage contents, consumes the stall/flush controls.
  modport master (
    output if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
    output id_ex_rd, id_ex_mem_re, id_ex_mc_start, mc_done,
    output branch_taken, stall_clr,
    input  pc_we, if_id_we, if_id_flush, id_ex_flush, ex_hold,
    input  mc_error, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2,
    input  id_ex_rd, id_ex_mem_re, id_ex_mc_start, mc_done,
    input  branch_taken, stall_clr,
    output pc_we, if_id_we, if_id_flush, id_ex_flush, ex_hold,
    output mc_error, stall_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use / multi-cycle / branch stall and flush controller
module hazard_control_unit #(
  parameter int LOAD_LAT   = 1,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  hazard_control_unit_if.slave hz
);

  // Load counter only ever holds LOAD_LAT-1; timeout counter holds up to MC_TIMEOUT-1.
  localparam int LW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam int TW = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LSTALL  = 2'd1,
    MC_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q;
  logic             err_set;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             lu_hit;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_hold;

  // Load-use: the load in EX writes a register the ID instruction actually reads (x0 never hazards).
  assign lu_hit = hz.id_ex_mem_re && (hz.id_ex_rd != 5'd0) &&
                  ((hz.if_id_use_rs1 && (hz.if_id_rs1 == hz.id_ex_rd)) ||
                   (hz.if_id_use_rs2 && (hz.if_id_rs2 == hz.id_ex_rd)));

  // State, stall counters and sticky timeout flag; reset drops any pending stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lcnt_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      tmo_q   <= tmo_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Next state and same-cycle pipeline controls; reset forces a frozen, flushed pipe.
  always_comb begin
    state_d     = state_q;
    lcnt_d      = lcnt_q;
    tmo_d       = tmo_q;
    err_set     = 1'b0;
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_hold     = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.branch_taken) begin
          // Redirect wins over everything, including an (illegal) simultaneous mc_start.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (hz.id_ex_mc_start) begin
          pc_we    = 1'b0;
          if_id_we = 1'b0;
          if (!hz.mc_done) begin
            ex_hold = 1'b1;
            state_d = MC_WAIT;
            tmo_d   = TW'(1);
          end
        end else if (lu_hit) begin
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LSTALL;
            lcnt_d  = LW'(LOAD_LAT - 1);
          end
        end
      end
      LSTALL: begin
        // EX holds a bubble here, so no branch can resolve and lu_hit is not rechecked.
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
        if (lcnt_q == LW'(1)) begin
          state_d = RUN;
        end else begin
          lcnt_d = lcnt_q - LW'(1);
        end
      end
      MC_WAIT: begin
        pc_we    = 1'b0;
        if_id_we = 1'b0;
        if (hz.mc_done) begin
          state_d = RUN;
        end else begin
          ex_hold = 1'b1;
          if (tmo_q >= TW'(MC_TIMEOUT - 1)) begin
            err_set = 1'b1;
            state_d = RUN;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (!rst_n) begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_hold     = 1'b0;
    end
  end

  // Saturating count of cycles the PC was frozen; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (hz.stall_clr) begin
      stall_cnt_q <= '0;
    end else if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hz.pc_we       = pc_we;
  assign hz.if_id_we    = if_id_we;
  assign hz.if_id_flush = if_id_flush;
  assign hz.id_ex_flush = id_ex_flush;
  assign hz.ex_hold     = ex_hold;
  assign hz.mc_error    = err_q;
  assign hz.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  hazard_control_unit_if #(.CNT_W(16)) ia ();
  hazard_control_unit_if #(.CNT_W(4))  ib ();

  // Unit A: LOAD_LAT=1, default timeout, 16-bit counter.
  hazard_control_unit #(.LOAD_LAT(1), .MC_TIMEOUT(64), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (ia)
  );

  // Unit B: LOAD_LAT=3, MC_TIMEOUT=4, 4-bit counter; same stimulus as A.
  hazard_control_unit #(.LOAD_LAT(3), .MC_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (ib)
  );

  assign ib.if_id_rs1      = ia.if_id_rs1;
  assign ib.if_id_rs2      = ia.if_id_rs2;
  assign ib.if_id_use_rs1  = ia.if_id_use_rs1;
  assign ib.if_id_use_rs2  = ia.if_id_use_rs2;
  assign ib.id_ex_rd       = ia.id_ex_rd;
  assign ib.id_ex_mem_re   = ia.id_ex_mem_re;
  assign ib.id_ex_mc_start = ia.id_ex_mc_start;
  assign ib.mc_done        = ia.mc_done;
  assign ib.branch_taken   = ia.branch_taken;
  assign ib.stall_clr      = ia.stall_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ia.if_id_rs1      = 5'd0;
    ia.if_id_rs2      = 5'd0;
    ia.if_id_use_rs1  = 1'b0;
    ia.if_id_use_rs2  = 1'b0;
    ia.id_ex_rd       = 5'd0;
    ia.id_ex_mem_re   = 1'b0;
    ia.id_ex_mc_start = 1'b0;
    ia.mc_done        = 1'b0;
    ia.branch_taken   = 1'b0;
    ia.stall_clr      = 1'b0;
  endtask

  task automatic load_use_rs2();
    ia.id_ex_mem_re  = 1'b1;
    ia.id_ex_rd      = 5'd5;
    ia.if_id_rs2     = 5'd5;
    ia.if_id_use_rs2 = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle();

    // Reset values while rst_n is low.
    #3;
    check("rst_pc_we",       {31'd0, ia.pc_we},       32'd0);
    check("rst_if_id_we",    {31'd0, ia.if_id_we},    32'd0);
    check("rst_if_id_flush", {31'd0, ia.if_id_flush}, 32'd1);
    check("rst_id_ex_flush", {31'd0, ia.id_ex_flush}, 32'd1);
    check("rst_ex_hold",     {31'd0, ia.ex_hold},     32'd0);
    check("rst_mc_error",    {31'd0, ia.mc_error},    32'd0);
    check("rst_count",       {16'd0, ia.stall_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("run_pc_we",       {31'd0, ia.pc_we},       32'd1);
    check("run_if_id_we",    {31'd0, ia.if_id_we},    32'd1);
    check("run_flush",       {30'd0, ia.if_id_flush, ia.id_ex_flush}, 32'd0);

    // Load-use through rs2, LOAD_LAT=1: a single bubble.
    tick();
    load_use_rs2();
    #1;
    check("lu_pc_we",        {31'd0, ia.pc_we},       32'd0);
    check("lu_if_id_we",     {31'd0, ia.if_id_we},    32'd0);
    check("lu_id_ex_flush",  {31'd0, ia.id_ex_flush}, 32'd1);
    tick();
    idle();
    #1;
    check("lu_after_pc_we",  {31'd0, ia.pc_we},       32'd1);
    check("lu_count",        {16'd0, ia.stall_count}, 32'd1);

    // Destination x0 never hazards.
    load_use_rs2();
    ia.id_ex_rd  = 5'd0;
    ia.if_id_rs2 = 5'd0;
    #1;
    check("rd0_pc_we",       {31'd0, ia.pc_we},       32'd1);
    // Matching rs2 that the instruction does not read.
    tick();
    load_use_rs2();
    ia.if_id_use_rs2 = 1'b0;
    #1;
    check("nouse_pc_we",     {31'd0, ia.pc_we},       32'd1);
    // Hit through rs1 instead.
    tick();
    idle();
    ia.id_ex_mem_re  = 1'b1;
    ia.id_ex_rd      = 5'd9;
    ia.if_id_rs1     = 5'd9;
    ia.if_id_use_rs1 = 1'b1;
    #1;
    check("rs1_pc_we",       {31'd0, ia.pc_we},       32'd0);
    tick();
    idle();
    #1;
    check("rs1_count",       {16'd0, ia.stall_count}, 32'd2);

    // Multi-cycle op, done arrives 5 cycles after start.
    ia.id_ex_mc_start = 1'b1;
    #1;
    check("mc0_ex_hold",     {31'd0, ia.ex_hold},     32'd1);
    check("mc0_pc_we",       {31'd0, ia.pc_we},       32'd0);
    for (int i = 1; i < 5; i++) begin
      tick();
      #1;
      check($sformatf("mc%0d_ex_hold", i), {31'd0, ia.ex_hold}, 32'd1);
      check($sformatf("mc%0d_pc_we", i),   {31'd0, ia.pc_we},   32'd0);
    end
    tick();
    ia.mc_done = 1'b1;
    #1;
    check("mcdone_ex_hold",  {31'd0, ia.ex_hold},     32'd0);
    check("mcdone_pc_we",    {31'd0, ia.pc_we},       32'd0);
    tick();
    idle();
    #1;
    check("mcend_pc_we",     {31'd0, ia.pc_we},       32'd1);
    check("mcend_ex_hold",   {31'd0, ia.ex_hold},     32'd0);
    check("mc_count",        {16'd0, ia.stall_count}, 32'd8);
    check("mc_error_a",      {31'd0, ia.mc_error},    32'd0);

    // mc_start and mc_done in the same cycle: one stall, no hold, no MC_WAIT.
    ia.id_ex_mc_start = 1'b1;
    ia.mc_done        = 1'b1;
    #1;
    check("mcsame_ex_hold",  {31'd0, ia.ex_hold},     32'd0);
    check("mcsame_pc_we",    {31'd0, ia.pc_we},       32'd0);
    tick();
    idle();
    #1;
    check("mcsame_next_pc",  {31'd0, ia.pc_we},       32'd1);
    check("mcsame_count",    {16'd0, ia.stall_count}, 32'd9);

    // Branch with a simultaneous load-use hit: flush both, no stall.
    load_use_rs2();
    ia.branch_taken = 1'b1;
    #1;
    check("br_pc_we",        {31'd0, ia.pc_we},       32'd1);
    check("br_if_id_we",     {31'd0, ia.if_id_we},    32'd1);
    check("br_flushes",      {30'd0, ia.if_id_flush, ia.id_ex_flush}, 32'd3);
    tick();
    idle();
    // Illegal branch + mc_start: branch wins, MC_WAIT not entered.
    ia.branch_taken   = 1'b1;
    ia.id_ex_mc_start = 1'b1;
    #1;
    check("brmc_pc_we",      {31'd0, ia.pc_we},       32'd1);
    check("brmc_ex_hold",    {31'd0, ia.ex_hold},     32'd0);
    tick();
    idle();
    #1;
    check("brmc_next_pc",    {31'd0, ia.pc_we},       32'd1);
    check("br_count",        {16'd0, ia.stall_count}, 32'd9);

    // stall_clr wins over a same-cycle increment.
    load_use_rs2();
    ia.stall_clr = 1'b1;
    tick();
    idle();
    #1;
    check("clr_count_a",     {16'd0, ia.stall_count}, 32'd0);

    // Fresh reset for unit B checks.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();

    // LOAD_LAT=3: exactly three bubble cycles.
    load_use_rs2();
    #1;
    check("ll0_pc_we",       {31'd0, ib.pc_we},       32'd0);
    check("ll0_flush",       {31'd0, ib.id_ex_flush}, 32'd1);
    tick();
    idle();
    for (int i = 1; i < 3; i++) begin
      #1;
      check($sformatf("ll%0d_pc_we", i), {31'd0, ib.pc_we},       32'd0);
      check($sformatf("ll%0d_flush", i), {31'd0, ib.id_ex_flush}, 32'd1);
      tick();
    end
    #1;
    check("ll_end_pc_we",    {31'd0, ib.pc_we},       32'd1);
    check("ll_end_flush",    {31'd0, ib.id_ex_flush}, 32'd0);
    check("ll_count",        {28'd0, ib.stall_count}, 32'd3);

    // MC_TIMEOUT=4 with no mc_done: error after 4 stall cycles.
    ia.id_ex_mc_start = 1'b1;
    #1;
    check("to0_ex_hold",     {31'd0, ib.ex_hold},     32'd1);
    tick();
    idle();
    tick();
    tick();
    #1;
    check("to3_mc_error",    {31'd0, ib.mc_error},    32'd0);
    check("to3_ex_hold",     {31'd0, ib.ex_hold},     32'd1);
    tick();
    #1;
    check("to4_mc_error",    {31'd0, ib.mc_error},    32'd1);
    check("to4_pc_we",       {31'd0, ib.pc_we},       32'd1);
    check("to4_ex_hold",     {31'd0, ib.ex_hold},     32'd0);
    check("to_count",        {28'd0, ib.stall_count}, 32'd7);
    tick();
    #1;
    check("to_sticky",       {31'd0, ib.mc_error},    32'd1);

    // 20 consecutive stall cycles saturate the 4-bit counter.
    load_use_rs2();
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    idle();
    #1;
    check("sat_count",       {28'd0, ib.stall_count}, 32'd15);
    tick();
    tick();
    tick();
    ia.stall_clr = 1'b1;
    tick();
    idle();
    #1;
    check("clr_count_b",     {28'd0, ib.stall_count}, 32'd0);

    // Asynchronous reset while in MC_WAIT.
    ia.id_ex_mc_start = 1'b1;
    tick();
    idle();
    #1;
    check("rmc_ex_hold",     {31'd0, ib.ex_hold},     32'd1);
    rst_n = 1'b0;
    #1;
    check("rmc_pc_we",       {31'd0, ib.pc_we},       32'd0);
    check("rmc_if_id_flush", {31'd0, ib.if_id_flush}, 32'd1);
    check("rmc_id_ex_flush", {31'd0, ib.id_ex_flush}, 32'd1);
    check("rmc_ex_hold_rst", {31'd0, ib.ex_hold},     32'd0);
    check("rmc_mc_error",    {31'd0, ib.mc_error},    32'd0);
    check("rmc_count",       {28'd0, ib.stall_count}, 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("rmc_run_pc_we",   {31'd0, ib.pc_we},       32'd1);
    tick();
    #1;
    check("rmc_after_pc_we", {31'd0, ib.pc_we},       32'd1);
    check("rmc_after_hold",  {31'd0, ib.ex_hold},     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
